// File: rtl/mul32_seq_pkg.sv
// Shared constants for the sequential multiply-add: state codes, the step count
// and the state type, which is also driven out on the debug port.
package mul32_seq_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam int ITER = 32;

    typedef enum logic [1:0] {
        ST_IDLE = S_IDLE,
        ST_BUSY = S_BUSY,
        ST_DONE = S_DONE
    } state_e;

endpackage

// File: rtl/mul32_seq_if.sv
// Operand and result handshake bundle for mul32_seq.
// Handshake: a transfer happens on a rising edge where valid and ready are both high;
// valid may not drop and its data may not change until that edge.
interface mul32_seq_if #(parameter int K = 32);

    logic            in_valid;
    logic            in_ready;
    logic [31:0]     q;
    logic [K-1:0]    d;
    logic [K-1:0]    r;
    logic            out_valid;
    logic            out_ready;
    logic [K+31:0]   x;

    modport master (
        output in_valid, q, d, r, out_ready,
        input  in_ready, out_valid, x
    );

    modport slave (
        input  in_valid, q, d, r, out_ready,
        output in_ready, out_valid, x
    );

endinterface

// File: rtl/mul32_seq.sv
// Radix-2 shift-add multiply-add: x = q*d + r over a fixed 32 BUSY cycles,
// rebuilding the dividend from a div32 quotient/divisor/remainder.
module mul32_seq
    import mul32_seq_pkg::*;
#(
    parameter int K = 32
) (
    input  logic        clk,
    input  logic        rstn,
    mul32_seq_if.slave  bus,
    output state_e      dbg_state_o
);

    localparam int W = K + 32;

    state_e         state_q;
    logic [W-1:0]   acc_q;
    logic [W-1:0]   msh_q;
    logic [31:0]    qsh_q;
    logic [4:0]     cnt_q;
    logic           in_ready_q;
    logic           out_valid_q;

    logic [W-1:0]   acc_d;
    logic           last_step;

    // The sum never exceeds W bits, so no carry-out is kept.
    assign acc_d     = qsh_q[0] ? (acc_q + msh_q) : acc_q;
    assign last_step = (cnt_q == 5'(ITER - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            msh_q       <= '0;
            qsh_q       <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        acc_q      <= {32'b0, bus.r};
                        msh_q      <= {32'b0, bus.d};
                        qsh_q      <= bus.q;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    acc_q <= acc_d;
                    msh_q <= msh_q << 1;
                    qsh_q <= qsh_q >> 1;
                    cnt_q <= cnt_q + 5'd1;
                    if (last_step) begin
                        out_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // acc is frozen here, so x stays stable under back-pressure.
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.x         = acc_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_mul32_seq.sv
// Bench for mul32_seq: directed corner cases plus random round-trip triples
// (q, d, r<d) checked against q*d+r computed with plain wide arithmetic.
module tb_mul32_seq;
    import mul32_seq_pkg::*;

    localparam int K = 32;
    localparam int W = K + 32;

    logic   clk  = 1'b0;
    logic   rstn = 1'b0;
    state_e dbg_state;

    mul32_seq_if #(.K(K)) bus ();

    mul32_seq #(.K(K)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    int           n_checks = 0;
    int           n_errors = 0;
    logic [W-1:0] exp_q[$];
    int           acc_edge = 0;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [W-1:0] model(input logic [31:0] q, input logic [K-1:0] d,
                                           input logic [K-1:0] r);
        return W'(q) * W'(d) + W'(r);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] q, input logic [K-1:0] d, input logic [K-1:0] r);
        int t = 0;
        bus.q        = q;
        bus.d        = d;
        bus.r        = r;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && t < 200) begin
            step();
            t++;
        end
        if (!bus.in_ready) chk("accept_timeout", W'(bus.in_ready), 1);
        step();
        acc_edge = cyc;
        exp_q.push_back(model(q, d, r));
        bus.in_valid = 1'b0;
    endtask

    task automatic recv(input int stall, input bit check_lat);
        int           t = 0;
        logic [W-1:0] x0;
        logic [W-1:0] e;
        while (!bus.out_valid && t < 200) begin
            step();
            t++;
        end
        chk("out_valid_seen", W'(bus.out_valid), 1);
        x0 = bus.x;
        repeat (stall) begin
            step();
            chk("x_stable", bus.x, x0);
            chk("out_valid_hold", W'(bus.out_valid), 1);
            chk("in_ready_low", W'(bus.in_ready), 0);
        end
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        if (check_lat) chk("latency", W'(cyc - acc_edge), 33);
        if (exp_q.size() == 0) begin
            chk("exp_empty", W'(exp_q.size()), 1);
        end else begin
            e = exp_q.pop_front();
            chk("x", x0, e);
        end
        chk("out_valid_drop", W'(bus.out_valid), 0);
    endtask

    // ---------------- stimulus ----------------
    logic [31:0]  rq;
    logic [K-1:0] rd, rr;
    int           mode;

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.q         = '0;
        bus.d         = '0;
        bus.r         = '0;

        // reset values
        repeat (3) step();
        chk("rst_in_ready", W'(bus.in_ready), 1);
        chk("rst_out_valid", W'(bus.out_valid), 0);
        chk("rst_x", bus.x, 0);
        chk("rst_state", W'(dbg_state), W'(ST_IDLE));
        rstn = 1'b1;
        step();

        // basic, with latency
        send(32'd7, 32'd6, 32'd5);
        chk("busy_in_ready", W'(bus.in_ready), 0);
        recv(0, 1);

        // maximum operands
        send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        recv(0, 1);
        chk("max_const", model(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF),
            64'hFFFF_FFFF_0000_0000);

        // zero operands
        send(32'd0, 32'h1234, 32'd9);
        recv(0, 1);
        send(32'd5, 32'd0, 32'd3);
        recv(0, 1);

        // out_ready high throughout BUSY has no effect
        send(32'h8000_0001, 32'hDEAD_BEEF, 32'h1);
        bus.out_ready = 1'b1;
        recv(0, 1);

        // back-pressure with next operands already waiting
        send(32'd1000, 32'd77, 32'd12);
        bus.q        = 32'hCAFE_0001;
        bus.d        = 32'h0001_0003;
        bus.r        = 32'h2;
        bus.in_valid = 1'b1;
        recv(10, 0);
        chk("bp_idle_ready", W'(bus.in_ready), 1);
        step();
        acc_edge = cyc;
        exp_q.push_back(model(32'hCAFE_0001, 32'h0001_0003, 32'h2));
        bus.in_valid = 1'b0;
        chk("bp_second_accept", W'(bus.in_ready), 0);
        recv(0, 1);

        // reset 15 cycles into BUSY
        send(32'h1234_5678, 32'h9ABC_DEF0, 32'h55);
        repeat (15) step();
        rstn = 1'b0;
        #1;
        chk("rst_busy_out_valid", W'(bus.out_valid), 0);
        chk("rst_busy_x", bus.x, 0);
        chk("rst_busy_state", W'(dbg_state), W'(ST_IDLE));
        exp_q.delete();
        step();
        step();
        rstn = 1'b1;
        chk("rst_busy_in_ready", W'(bus.in_ready), 1);
        send(32'd7, 32'd6, 32'd5);
        recv(0, 1);

        // reset while result is waiting in DONE
        send(32'd3, 32'd3, 32'd1);
        repeat (36) step();
        chk("done_wait_valid", W'(bus.out_valid), 1);
        rstn = 1'b0;
        #1;
        chk("rst_done_out_valid", W'(bus.out_valid), 0);
        chk("rst_done_x", bus.x, 0);
        exp_q.delete();
        step();
        rstn = 1'b1;
        step();

        // random round-trip triples: r < d so (q, d, r) is a valid division result
        for (int i = 0; i < 1000; i++) begin
            rd = $urandom;
            if (rd == 0) rd = 1;
            rq = $urandom;
            rr = $urandom % rd;
            mode = $urandom_range(0, 2);
            send(rq, rd, rr);
            if (mode == 1) begin
                bus.out_ready = 1'b1;
                recv(0, 1);
            end else if (mode == 2) begin
                recv($urandom_range(1, 3), 0);
            end else begin
                recv(0, 1);
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
